// File: rtl/regfile_clr.sv
// Two-read/one-write register file with registered reads, write bypass and a clear sequencer.
// Optional hard-wired zero register: define REGFILE_ZERO_REG_EN.
module regfile_clr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              wr_ok;

`ifdef REGFILE_ZERO_REG_EN
    assign wr_ok = (wr_addr != '0);
`else
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        rd_a_d    = rd_a_q;
        rd_b_d    = rd_b_q;
        mem_we    = 1'b0;
        mem_wa    = wr_addr;
        mem_wd    = wr_data;
        unique case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_idx_q;
                mem_wd = '0;
                rd_a_d = '0;
                rd_b_d = '0;
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = S_IDLE;
                    ready_d   = 1'b1;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            S_IDLE: begin
                rd_a_d = mem[rd_addr_a];
                rd_b_d = mem[rd_addr_b];
                if (clear) begin
                    // Write on the accept edge is dropped; reads see the old array.
                    state_d   = S_CLEAR;
                    clr_idx_d = '0;
                    ready_d   = 1'b0;
                end else begin
                    mem_we = wr_en && wr_ok;
                    if (mem_we && (wr_addr == rd_addr_a)) rd_a_d = wr_data;
                    if (mem_we && (wr_addr == rd_addr_b)) rd_b_d = wr_data;
                end
`ifdef REGFILE_ZERO_REG_EN
                if (rd_addr_a == '0) rd_a_d = '0;
                if (rd_addr_b == '0) rd_b_d = '0;
`endif
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
        end
    end

    // Array has no reset; the clear sequencer zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_regfile_clr.sv
// Self-checking bench for regfile_clr: vector table, corner sequences, random vs reference model.
module tb_regfile_clr;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [4:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
    logic [31:0] rd_data_a, rd_data_b, wr_data = '0;
    logic        wr_en = 1'b0;
    logic        ready;

    regfile_clr #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: array contents, and edges left until the array is usable.
    logic [31:0] m [DEPTH];
    int          rem;

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        rem = DEPTH;
    endtask

    task automatic step();
        logic [31:0] ea, eb;
        bit wok;
        if (rem > 0) begin
            ea = '0;
            eb = '0;
            rem--;
        end else if (clear) begin
            ea = m[rd_addr_a];
            eb = m[rd_addr_b];
            model_zero();
        end else begin
            wok = wr_en && !(ZR && wr_addr == 5'd0);
            ea = (wok && wr_addr == rd_addr_a) ? wr_data : m[rd_addr_a];
            eb = (wok && wr_addr == rd_addr_b) ? wr_data : m[rd_addr_b];
            if (wok) m[wr_addr] = wr_data;
            if (ZR && rd_addr_a == 5'd0) ea = '0;
            if (ZR && rd_addr_b == 5'd0) eb = '0;
        end
        @(posedge clk);
        #1;
        chk("ready", {31'd0, ready}, {31'd0, rem == 0});
        chk("rd_a", rd_data_a, ea);
        chk("rd_b", rd_data_b, eb);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        chk({name, "_rd_a"}, rd_data_a, 32'd0);
        chk({name, "_rd_b"}, rd_data_b, 32'd0);
        chk({name, "_ready"}, {31'd0, ready}, 32'd0);
        model_zero();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic count_ready(input string name, input int clr_at);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            clear = (i == clr_at);
            step();
            n++;
            if (ready) break;
        end
        clear = 1'b0;
        chk(name, n, 32);
    endtask

    localparam logic [31:0] Z0 = ZR ? 32'h0 : 32'hFFFF_FFFF;

    initial begin
        vt[0] = '{1'b1, 5'd5, 32'h1234_5678, 5'd1, 5'd2, 32'h0, 32'h0};
        vt[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678};
        vt[2] = '{1'b1, 5'd6, 32'h11, 5'd5, 5'd6, 32'h1234_5678, 32'h11};
        vt[3] = '{1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd6, 32'hA5A5_A5A5, 32'h11};
        vt[4] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd7, Z0, 32'hA5A5_A5A5};
        vt[5] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, Z0, Z0};
        vt[6] = '{1'b1, 5'd5, 32'hCAFE_F00D, 5'd5, 5'd4, 32'hCAFE_F00D, 32'h0};

        model_zero();
        @(posedge clk);
        #1;
        chk("rst_rd_a", rd_data_a, 32'd0);
        chk("rst_rd_b", rd_data_b, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        reset = 1'b0;

        // Writes held during the power-up clear must be ignored.
        wr_en = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 40; i++) begin
            wr_addr = 5'(i);
            if (ready) break;
            step();
        end
        chk("init_clear_len", {31'd0, ready}, 32'd1);
        wr_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(DEPTH - 1 - i);
            step();
            chk("init_zero", rd_data_a, 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            wr_en = vt[i].we;
            wr_addr = vt[i].wa;
            wr_data = vt[i].wd;
            rd_addr_a = vt[i].ra;
            rd_addr_b = vt[i].rb;
            step();
            chk($sformatf("vec%0d_a", i), rd_data_a, vt[i].ea);
            chk($sformatf("vec%0d_b", i), rd_data_b, vt[i].eb);
        end

        // Fill, then clear with a same-edge write that must be dropped.
        for (int i = 1; i < DEPTH; i++) begin
            wr_en = 1'b1;
            wr_addr = 5'(i);
            wr_data = {8'(i), 24'h5A5A5A};
            step();
        end
        clear = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h99;
        rd_addr_a = 5'd1;
        rd_addr_b = 5'd2;
        step();
        chk("clr_edge_read", rd_data_a, {8'd1, 24'h5A5A5A});
        wr_en = 1'b0;
        count_ready("clear_len_repulse", 10);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'd3;
            step();
            chk("clr_zero", rd_data_a, 32'd0);
        end
        chk("drop3", rd_data_b, 32'd0);

        // Reset mid-IDLE with nonzero outputs.
        wr_en = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h77;
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd9;
        step();
        wr_en = 1'b0;
        step();
        chk("pre_rst_rd", rd_data_a, 32'h77);
        do_reset("rst_idle");
        for (int i = 0; i < 10; i++) step();
        do_reset("rst_clr10");
        count_ready("rst_clear_len", -1);
        step();
        chk("post_rst_9", rd_data_a, 32'd0);

        for (int i = 0; i < 600; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr_b = 5'($urandom_range(0, 31));
            clear = ($urandom_range(0, 59) == 0);
            step();
        end
        clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
